// File: rtl/store_align_unit.sv
// MEM-stage store aligner: turns a byte-addressed SB/SH/SW into lane-aligned
// word writes, splitting word-crossing stores into two registered beats.
module store_align_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid_EXMEM,
  input  logic [2:0]        st_funct3_EXMEM,
  input  logic [31:0]       st_addr_EXMEM,
  input  logic [WIDTH-1:0]  st_data_EXMEM,
  input  logic [1:0]        mem_sel_EXMEM,
  output logic              stall_out,
  output logic              mem0_wr_en,
  output logic              mem3_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [WIDTH-1:0]  mem_wr_data,
  output logic [3:0]        mem_wr_be,
  output logic              st_err
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t               state;
  logic [1:0]           off_p0;
  logic [ADDR_W-1:0]    word_p0;
  logic [7:0]           m8_p0;
  logic [2*WIDTH-1:0]   d64_p0;
  logic                 legal_p0;
  logic                 mapped_p0;
  logic [ADDR_W-1:0]    sec_addr_p1;
  logic [3:0]           sec_be_p1;
  logic [WIDTH-1:0]     sec_data_p1;
  logic                 sec_mem3_p1;
  logic                 unused_addr_bits;

  function automatic logic [7:0] lane_enables(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] m4;
    case (f3)
      3'b000:  m4 = 4'b0001;
      3'b001:  m4 = 4'b0011;
      3'b010:  m4 = 4'b1111;
      default: m4 = 4'b0000;
    endcase
    return {4'b0000, m4} << off;
  endfunction

  function automatic logic [2*WIDTH-1:0] lane_data(input logic [WIDTH-1:0] d, input logic [1:0] off);
    return {{WIDTH{1'b0}}, d} << {off, 3'b000};
  endfunction

  assign unused_addr_bits = ^st_addr_EXMEM[31:ADDR_W+2];

  // p0: decode of the EX/MEM store request
  always_comb begin
    off_p0    = st_addr_EXMEM[1:0];
    word_p0   = st_addr_EXMEM[ADDR_W+1:2];
    legal_p0  = (st_funct3_EXMEM == 3'b000) || (st_funct3_EXMEM == 3'b001) ||
                (st_funct3_EXMEM == 3'b010);
    mapped_p0 = (mem_sel_EXMEM == 2'b00) || (mem_sel_EXMEM == 2'b11);
    m8_p0     = lane_enables(st_funct3_EXMEM, off_p0);
    d64_p0    = lane_data(st_data_EXMEM, off_p0);
  end

  // p1: registered write beats; outputs default to zero every idle cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      stall_out   <= 1'b0;
      mem0_wr_en  <= 1'b0;
      mem3_wr_en  <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_wr_be   <= 4'b0000;
      st_err      <= 1'b0;
      sec_addr_p1 <= '0;
      sec_be_p1   <= 4'b0000;
      sec_data_p1 <= '0;
      sec_mem3_p1 <= 1'b0;
    end else begin
      stall_out   <= 1'b0;
      mem0_wr_en  <= 1'b0;
      mem3_wr_en  <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_wr_be   <= 4'b0000;
      st_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (st_valid_EXMEM) begin
            if (!legal_p0) begin
              st_err <= 1'b1;
            end else if (mapped_p0) begin
              mem0_wr_en  <= (mem_sel_EXMEM == 2'b00);
              mem3_wr_en  <= (mem_sel_EXMEM == 2'b11);
              mem_wr_addr <= word_p0;
              mem_wr_be   <= m8_p0[3:0];
              mem_wr_data <= d64_p0[WIDTH-1:0];
              // Upper lanes spill into the next word: queue the second beat.
              if (|m8_p0[7:4]) begin
                state       <= SECOND;
                stall_out   <= 1'b1;
                sec_addr_p1 <= word_p0 + ADDR_W'(1);
                sec_be_p1   <= m8_p0[7:4];
                sec_data_p1 <= d64_p0[2*WIDTH-1:WIDTH];
                sec_mem3_p1 <= (mem_sel_EXMEM == 2'b11);
              end
            end
          end
        end
        SECOND: begin
          mem0_wr_en  <= !sec_mem3_p1;
          mem3_wr_en  <= sec_mem3_p1;
          mem_wr_addr <= sec_addr_p1;
          mem_wr_be   <= sec_be_p1;
          mem_wr_data <= sec_data_p1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Scoreboard bench for store_align_unit: expected write beats are queued at
// issue time and popped by a monitor whenever the DUT writes or flags an error.
module tb_store_align_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        st_valid_EXMEM = 1'b0;
  logic [2:0]  st_funct3_EXMEM = 3'b000;
  logic [31:0] st_addr_EXMEM = 32'h0;
  logic [31:0] st_data_EXMEM = 32'h0;
  logic [1:0]  mem_sel_EXMEM = 2'b00;
  logic        stall_out;
  logic        mem0_wr_en;
  logic        mem3_wr_en;
  logic [9:0]  mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_wr_be;
  logic        st_err;

  int errors = 0;
  int checks = 0;

  // {en0, en3, addr[9:0], be[3:0], data[31:0], stall, err}
  typedef logic [49:0] beat_t;
  beat_t exp_q[$];

  store_align_unit #(.WIDTH(32), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid_EXMEM(st_valid_EXMEM), .st_funct3_EXMEM(st_funct3_EXMEM),
    .st_addr_EXMEM(st_addr_EXMEM), .st_data_EXMEM(st_data_EXMEM),
    .mem_sel_EXMEM(mem_sel_EXMEM), .stall_out(stall_out),
    .mem0_wr_en(mem0_wr_en), .mem3_wr_en(mem3_wr_en),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_be(mem_wr_be), .st_err(st_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic beat_t mk(input logic e0, input logic e3, input logic [9:0] a,
                               input logic [3:0] be, input logic [31:0] d,
                               input logic stl, input logic err);
    return {e0, e3, a, be, d, stl, err};
  endfunction

  function automatic beat_t cur_beat();
    return {mem0_wr_en, mem3_wr_en, mem_wr_addr, mem_wr_be, mem_wr_data, stall_out, st_err};
  endfunction

  // Monitor: pop and compare on every output event
  always @(negedge clk) begin
    if (rst_n) begin
      chk("en_exclusive", 64'(mem0_wr_en & mem3_wr_en), 64'd0);
      chk("be_without_en", 64'((mem_wr_be != 4'b0) && !(mem0_wr_en || mem3_wr_en)), 64'd0);
      if (mem0_wr_en || mem3_wr_en || st_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %h, expected none", cur_beat());
        end else begin
          chk("beat", 64'(cur_beat()), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // Present a store and hold it while stall_out is high; returns after the accept edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, output int waits);
    @(negedge clk);
    st_valid_EXMEM  = 1'b1;
    st_funct3_EXMEM = f3;
    st_addr_EXMEM   = a;
    st_data_EXMEM   = d;
    mem_sel_EXMEM   = s;
    waits = 0;
    while (stall_out && waits < 4) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 4) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout: got %0d cycles, expected < 4", waits);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    st_valid_EXMEM = 1'b0;
  endtask

  task automatic chk_quiet(input string name);
    chk(name, 64'(cur_beat()), 64'd0);
  endtask

  int w;

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_quiet("reset_outputs");
    repeat (2) @(negedge clk);
    chk_quiet("reset_hold");
    rst_n = 1'b1;

    // Back-to-back aligned stores, then an idle cycle
    exp_q.push_back(mk(1, 0, 10'd4, 4'b1111, 32'hDEADBEEF, 0, 0));
    issue(3'b010, 32'h0000_0010, 32'hDEADBEEF, 2'b00, w);
    exp_q.push_back(mk(0, 1, 10'd1, 4'b1000, 32'hA500_0000, 0, 0));
    issue(3'b000, 32'h0000_0007, 32'h0000_00A5, 2'b11, w);
    chk("sb_no_wait", 64'(w), 64'd0);
    idle();
    @(negedge clk);
    chk_quiet("idle_after_stores");

    // Split SH, with a SW presented during the stall cycle
    exp_q.push_back(mk(1, 0, 10'd2, 4'b1000, 32'h3400_0000, 1, 0));
    exp_q.push_back(mk(1, 0, 10'd3, 4'b0001, 32'h0000_0012, 0, 0));
    issue(3'b001, 32'h0000_000B, 32'h0000_1234, 2'b00, w);
    exp_q.push_back(mk(0, 1, 10'd8, 4'b1111, 32'hCAFEF00D, 0, 0));
    issue(3'b010, 32'h0000_0020, 32'hCAFEF00D, 2'b11, w);
    chk("stall_wait_cycles", 64'(w), 64'd1);
    idle();

    // Split SW wrapping the word address
    exp_q.push_back(mk(1, 0, 10'h3FF, 4'b1100, 32'h3344_0000, 1, 0));
    exp_q.push_back(mk(1, 0, 10'h000, 4'b0011, 32'h0000_1122, 0, 0));
    issue(3'b010, 32'h0000_0FFE, 32'h11223344, 2'b00, w);
    idle();
    repeat (2) @(negedge clk);

    // Illegal funct3 pulses st_err once
    exp_q.push_back(mk(0, 0, 10'd0, 4'b0000, 32'h0, 0, 1));
    issue(3'b011, 32'h0000_0010, 32'h12345678, 2'b00, w);
    idle();
    @(negedge clk);
    chk("st_err_one_cycle", 64'(st_err), 64'd0);

    // Unmapped memory selects are dropped, even when they would split
    issue(3'b010, 32'h0000_0010, 32'h12345678, 2'b01, w);
    idle();
    chk_quiet("unmapped_sw");
    issue(3'b001, 32'h0000_000B, 32'h0000_1234, 2'b10, w);
    idle();
    chk_quiet("unmapped_split_sh");
    @(negedge clk);
    chk_quiet("unmapped_after");

    // Reset during the beat-1 cycle drops beat 2
    exp_q.push_back(mk(1, 0, 10'd2, 4'b1000, 32'h3400_0000, 1, 0));
    issue(3'b001, 32'h0000_000B, 32'h0000_1234, 2'b00, w);
    idle();
    #2 rst_n = 1'b0;
    #1 chk_quiet("reset_mid_split");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_quiet("no_beat2_after_reset");

    exp_q.push_back(mk(1, 0, 10'h010, 4'b1111, 32'h55AA55AA, 0, 0));
    issue(3'b010, 32'h0000_0040, 32'h55AA55AA, 2'b00, w);
    idle();
    repeat (3) @(negedge clk);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no end of test, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/store_align_unit.md
Name: store_align_unit

Overview:
- MEM-stage store path; the write-side counterpart of the write-back load extractor.
- Takes a store's byte address, funct3 and rs2 data from EX/MEM.
- Produces word address, lane-shifted write data and byte enables for data memory 0 or memory 3.
- Stores that cross a word boundary are split into two registered write beats; the pipeline is stalled for one cycle while this happens.

Parameters:
- WIDTH, 32, data word width in bits. Fixed at 32; byte-enable logic assumes 4 lanes.
- ADDR_W, 10, word-address width presented to the memories.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- st_valid_EXMEM  in  1  store request present this cycle
- st_funct3_EXMEM  in  3  SB=000, SH=001, SW=010; others illegal
- st_addr_EXMEM  in  32  byte address from ALU
- st_data_EXMEM  in  WIDTH  rs2 store data, unaligned (value in low bits)
- mem_sel_EXMEM  in  2  target memory: 00=mem0, 11=mem3, 01/10=unmapped
- stall_out  out  1  hold EX/MEM and earlier stages this cycle
- mem0_wr_en  out  1  write strobe to mem0
- mem3_wr_en  out  1  write strobe to mem3
- mem_wr_addr  out  ADDR_W  word address
- mem_wr_data  out  WIDTH  lane-aligned write data
- mem_wr_be  out  4  byte enables; bit i covers data[8i+7:8i]
- st_err  out  1  one-cycle pulse on illegal funct3

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, stored second-beat data cleared. Reset mid-split drops the pending second beat.
- States: IDLE, SECOND.
- Accept: a request is accepted at a clock edge when st_valid_EXMEM=1 and state=IDLE. Requests presented while state=SECOND are ignored; upstream holds them because stall_out=1.
- Decode on accept:
  - off = addr[1:0]; word = addr[ADDR_W+1:2].
  - mask4 = 0001 for SB, 0011 for SH, 1111 for SW.
  - m8 = {4'b0,mask4} << off.
  - d64 = {32'b0,data} << (8*off).
- Beat 1 (registered, visible the cycle after accept):
  - addr = word, be = m8[3:0], data = d64[31:0].
  - The enable for the selected memory is 1.
- Split: if m8[7:4] != 0, state goes to SECOND.
  - SECOND holds word+1 (wraps modulo 2^ADDR_W), m8[7:4], d64[63:32] and mem_sel.
  - stall_out=1 exactly during the beat-1 cycle.
  - The next edge presents beat 2: same memory, same output format. State returns to IDLE.
- Latency: 1 cycle for an aligned store; 2 consecutive write cycles for a split store. Back-to-back aligned stores sustain 1 per cycle.
- Idle cycles: enables=0, be=0, data=0, addr=0 (outputs not held).
- mem_sel 01/10: store is silently dropped. No enables, no split, no stall, no error.
- Illegal funct3 with valid: no write, no split. st_err=1 for the following cycle only.
- mem0_wr_en and mem3_wr_en are never high together.
- mem_wr_be is nonzero only when an enable is high.
- All outputs come from registers; there is no combinational path from inputs to outputs.

Test Plan:
- SW addr=0x0000_0010, data=0xDEADBEEF, sel=00 → next cycle:
  - mem0_wr_en=1, addr=4, be=1111, data=0xDEADBEEF, stall_out=0.
- SB addr=0x0000_0007, data=0x000000A5, sel=11 → mem3_wr_en=1, addr=1, be=1000, data=0xA5000000.
- SH addr=0x0000_000B, data=0x00001234, sel=00:
  - beat 1: addr=2, be=1000, data=0x34000000, stall_out=1.
  - beat 2 (next cycle): addr=3, be=0001, data=0x00000012, stall_out=0.
  - A store presented during the stall cycle is accepted only after it.
- SW addr=0x0000_0FFE with ADDR_W=10, data=0x11223344:
  - beat 1: addr=0x3FF, be=1100, data=0x33440000.
  - beat 2: addr=0x000, be=0011, data=0x00001122.
- funct3=011, valid → st_err=1 for one cycle, no enables. funct3=010 with sel=01 → no enables, st_err=0.
- Reset mid-split: assert rst_n=0 during the beat-1 cycle of the split SH above.
  - All outputs 0 immediately; no beat 2 after release.
  - The next SW completes normally.
